imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Byte-stream boot loader that writes a program image into the processor's instruction memory.
- It is the writer for the instruction memory that the fetch stage reads.
- It holds the core in reset while loading and releases it once a load completes with a valid checksum.
- It sits between the host byte link (UART receiver or bench driver) and the IMEM write port, beside the processor top.

Parameters:
- ADDR_W, 8, IMEM word-address width; capacity is 2^ADDR_W words.
- BASE_ADDR, 0, first word address written, in words.

Ports:
- clk  in  1  system clock
- rst_  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse that begins a load; honoured only in IDLE, DONE or ERR
- in_valid  in  1  byte-stream valid
- in_data  in  8  byte-stream data
- in_ready  out  1  loader can accept a byte this cycle
- imem_we  out  1  IMEM write-enable pulse
- imem_addr  out  ADDR_W  IMEM word address
- imem_wdata  out  32  IMEM write data
- core_rst_  out  1  core reset, active-low; 0 holds the processor in reset
- done  out  1  load finished, checksum good
- err  out  1  load aborted (length overflow or bad checksum)

Behaviour:
- Frame format:
  - LEN_LO, LEN_HI: 16-bit word count N, little-endian.
  - 4*N payload bytes: each word little-endian, LSB first.
  - CSUM: one byte, the XOR of all payload bytes only.
- Handshake: a byte is accepted on a cycle with in_valid && in_ready. in_ready=1 only in LEN_LO, LEN_HI, DATA and CSUM. in_data is ignored otherwise.
- States: IDLE, LEN_LO, LEN_HI, DATA, CSUM, DONE, ERR.
- Transitions:
  - IDLE/DONE/ERR --start--> LEN_LO. Clears done, err, word counter, byte index and running XOR; drives core_rst_=0.
  - LEN_LO --accept--> LEN_HI.
  - LEN_HI --accept-->:
    - ERR if N > 2^ADDR_W - BASE_ADDR;
    - CSUM if N == 0;
    - DATA otherwise.
  - DATA: a 2-bit byte index assembles the word. On acceptance of byte 3:
    - the next cycle has imem_we=1 for exactly one cycle, with imem_addr = BASE_ADDR + word_count and imem_wdata = the assembled word;
    - word_count increments;
    - after word N-1, the state goes to CSUM.
  - CSUM --accept-->:
    - DONE if the byte equals the running XOR;
    - ERR otherwise.
- Output registers:
  - DONE: done=1, core_rst_=1. IMEM writes are complete before core_rst_ rises.
  - ERR: err=1, core_rst_=0; stays there until start or rst_.
- Latency: write pulse 1 cycle after the 4th byte. done/core_rst_ rise 1 cycle after the CSUM byte is accepted. The loader sustains one byte per cycle.
- Reset values: IDLE, in_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, core_rst_=0, done=0, err=0.
- rst_ mid-load aborts to IDLE with reset values. Partially written IMEM contents are not cleared.
- start while in LEN_LO..CSUM is ignored.
- imem_addr and imem_wdata hold their last values when imem_we=0.
- Address arithmetic is ADDR_W bits. The overflow check is done at LEN_HI, so wrap never occurs.

Decomposition:
- Package imem_loader_pkg holds:
  - the state encoding (3-bit localparams);
  - the frame byte-order constants;
  - the CSUM_INIT = 8'h00 constant.
- Sub-module byte_to_word: a 4-byte little-endian packer with byte-index counter and word_valid pulse. The FSM, counters, checksum and core_rst_ stay in the top.

Test Plan:
- Normal load:
  - Stimulus: start, then bytes 02 00 93 00 50 00 13 01 A0 00 71 back-to-back.
  - Response: imem_we pulses with (0, 0x00500093) then (1, 0x00A00113); done=1 and core_rst_=1 one cycle after 0x71.
- Bad checksum:
  - Stimulus: same frame with CSUM byte 0x70.
  - Response: both writes still occur; err=1, done=0, core_rst_=0.
- Zero length:
  - Stimulus: bytes 00 00 00.
  - Response: no imem_we; done=1.
- Gapped valid:
  - Stimulus: the normal frame with in_valid low 3 cycles between each byte.
  - Response: identical writes and done; no write on idle cycles.
- Overflow:
  - Stimulus: ADDR_W=8, length bytes 01 01 (N=257).
  - Response: err=1 right after LEN_HI; no imem_we; in_ready=0.
- Reset mid-load and reload:
  - Stimulus: rst_=1 after 5 payload bytes.
  - Response: all outputs return to reset values. A following start plus the normal frame completes with done=1.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory boot loader.
//   - loader state encoding (3-bit) exposed on the debug port
//   - frame byte-order constants (little-endian length and payload words)
//   - checksum seed
package imem_loader_pkg;

  localparam logic [2:0] ST_IDLE_ENC   = 3'd0;
  localparam logic [2:0] ST_LEN_LO_ENC = 3'd1;
  localparam logic [2:0] ST_LEN_HI_ENC = 3'd2;
  localparam logic [2:0] ST_DATA_ENC   = 3'd3;
  localparam logic [2:0] ST_CSUM_ENC   = 3'd4;
  localparam logic [2:0] ST_DONE_ENC   = 3'd5;
  localparam logic [2:0] ST_ERR_ENC    = 3'd6;

  typedef enum logic [2:0] {
    ST_IDLE   = ST_IDLE_ENC,
    ST_LEN_LO = ST_LEN_LO_ENC,
    ST_LEN_HI = ST_LEN_HI_ENC,
    ST_DATA   = ST_DATA_ENC,
    ST_CSUM   = ST_CSUM_ENC,
    ST_DONE   = ST_DONE_ENC,
    ST_ERR    = ST_ERR_ENC
  } state_t;

  // Frame byte order: length is LEN_LO then LEN_HI; payload words arrive
  // least-significant byte first, so byte index 3 completes a word.
  localparam int         BYTES_PER_WORD = 4;
  localparam logic [1:0] LAST_BYTE_IDX  = 2'd3;

  localparam logic [7:0] CSUM_INIT = 8'h00;

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream and IMEM write-port bundle for the boot loader.
//   in_valid/in_data : host byte stream (host -> loader)
//   in_ready         : loader can take a byte this cycle
//   imem_we/addr/wdata : single-cycle instruction-memory write (loader -> IMEM)
// Handshake: a byte transfers on any rising clk edge where in_valid and
// in_ready are both 1; in_data is don't-care otherwise. The host may raise
// in_valid at any time and must hold in_data stable until the transfer.
// master = host/bench side, slave = loader side.
interface imem_loader_if #(
  parameter int ADDR_W = 8
);
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;

  modport master (
    output in_valid, in_data,
    input  in_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/imem_loader_byte_to_word.sv
// byte_to_word: little-endian 4-byte packer.
//   clk, rst_   : clock, synchronous active-high reset
//   clear       : restart assembly at byte 0 (new load)
//   byte_valid  : byte_data is consumed this cycle
//   byte_data   : incoming byte
//   word_valid  : one-cycle pulse, the cycle after byte 3 was consumed
//   word_data   : assembled word; holds its last value between pulses
//   byte_idx    : index of the next byte within the word
module byte_to_word
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst_,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        word_valid,
  output logic [31:0] word_data,
  output logic [1:0]  byte_idx
);

  // Bytes 0..2 of the word in flight; byte 3 goes straight into word_data.
  logic [23:0] lo_bytes;

  always_ff @(posedge clk) begin
    if (rst_) begin
      byte_idx   <= 2'd0;
      lo_bytes   <= 24'd0;
      word_valid <= 1'b0;
      word_data  <= 32'd0;
    end else begin
      word_valid <= 1'b0;
      if (clear) begin
        byte_idx <= 2'd0;
        lo_bytes <= 24'd0;
      end else if (byte_valid) begin
        byte_idx <= byte_idx + 2'd1;
        if (byte_idx == LAST_BYTE_IDX) begin
          word_data  <= {byte_data, lo_bytes};
          word_valid <= 1'b1;
        end else begin
          lo_bytes[{byte_idx, 3'b000} +: 8] <= byte_data;
        end
      end
    end
  end

endmodule

// File: rtl/imem_loader.sv
// imem_loader: byte-stream boot loader writing a program image into IMEM.
// Frame: LEN_LO LEN_HI (word count N), 4*N payload bytes (words LSB first),
// CSUM = XOR of the payload bytes. The core is held in reset (core_rst_=0)
// until a frame completes with a matching checksum.
//   clk, rst_   : clock, synchronous active-high reset
//   start       : pulse to begin a load (only from IDLE, DONE or ERR)
//   bus         : byte stream in, IMEM write port out (slave side)
//   core_rst_   : active-low core reset, 1 only in DONE
//   done / err  : load completed good / load aborted
//   state_dbg   : current loader state encoding
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0
) (
  input  logic       clk,
  input  logic       rst_,
  input  logic       start,
  imem_loader_if.slave bus,
  output logic       core_rst_,
  output logic       done,
  output logic       err,
  output logic [2:0] state_dbg
);

  // Largest word count that fits between BASE_ADDR and the top of IMEM.
  localparam logic [16:0]       CAPACITY = 17'((1 << ADDR_W) - BASE_ADDR);
  localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);

  state_t      state;
  logic [7:0]  len_lo;
  logic [15:0] len;
  logic [16:0] word_cnt;
  logic [7:0]  csum;
  logic [1:0]  byte_idx;

  logic        accept;
  logic        start_ok;
  logic        data_byte;
  logic        word_end;
  logic [15:0] new_len;

  assign accept    = bus.in_valid && bus.in_ready;
  assign start_ok  = start && (state == ST_IDLE || state == ST_DONE || state == ST_ERR);
  assign data_byte = accept && (state == ST_DATA);
  assign word_end  = data_byte && (byte_idx == LAST_BYTE_IDX);
  assign new_len   = {bus.in_data, len_lo};
  assign state_dbg = state;

  // The packer's registered word pulse is the IMEM write strobe, so the
  // write lands exactly one cycle after the fourth byte of each word.
  byte_to_word u_pack (
    .clk        (clk),
    .rst_       (rst_),
    .clear      (start_ok),
    .byte_valid (data_byte),
    .byte_data  (bus.in_data),
    .word_valid (bus.imem_we),
    .word_data  (bus.imem_wdata),
    .byte_idx   (byte_idx)
  );

  always_ff @(posedge clk) begin
    if (rst_) begin
      state         <= ST_IDLE;
      bus.in_ready  <= 1'b0;
      bus.imem_addr <= '0;
      core_rst_     <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
      len_lo        <= 8'd0;
      len           <= 16'd0;
      word_cnt      <= 17'd0;
      csum          <= CSUM_INIT;
    end else begin
      // Address is registered alongside the packer's word so both are
      // valid in the same cycle as imem_we.
      if (word_end) begin
        bus.imem_addr <= BASE + word_cnt[ADDR_W-1:0];
        word_cnt      <= word_cnt + 17'd1;
      end
      if (data_byte) begin
        csum <= csum ^ bus.in_data;
      end

      case (state)
        ST_IDLE, ST_DONE, ST_ERR: begin
          if (start) begin
            state        <= ST_LEN_LO;
            bus.in_ready <= 1'b1;
            done         <= 1'b0;
            err          <= 1'b0;
            core_rst_    <= 1'b0;
            word_cnt     <= 17'd0;
            csum         <= CSUM_INIT;
          end
        end
        ST_LEN_LO: begin
          if (accept) begin
            len_lo <= bus.in_data;
            state  <= ST_LEN_HI;
          end
        end
        ST_LEN_HI: begin
          if (accept) begin
            len <= new_len;
            // Rejecting oversize frames here guarantees addresses never wrap.
            if ({1'b0, new_len} > CAPACITY) begin
              state        <= ST_ERR;
              err          <= 1'b1;
              bus.in_ready <= 1'b0;
            end else if (new_len == 16'd0) begin
              state <= ST_CSUM;
            end else begin
              state <= ST_DATA;
            end
          end
        end
        ST_DATA: begin
          if (word_end && (word_cnt + 17'd1 == {1'b0, len})) begin
            state <= ST_CSUM;
          end
        end
        ST_CSUM: begin
          if (accept) begin
            bus.in_ready <= 1'b0;
            if (bus.in_data == csum) begin
              state     <= ST_DONE;
              done      <= 1'b1;
              core_rst_ <= 1'b1;
            end else begin
              state <= ST_ERR;
              err   <= 1'b1;
            end
          end
        end
        default: begin
          state        <= ST_IDLE;
          bus.in_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Testbench for imem_loader: directed frames plus randomized frames, with a
// cycle-stamped scoreboard of expected IMEM writes and end-of-frame status.
module tb_imem_loader;
  localparam int ADDR_W    = 8;
  localparam int BASE_ADDR = 0;
  localparam int CAP       = (1 << ADDR_W) - BASE_ADDR;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_ = 1'b1;
  logic start = 1'b0;
  logic core_rst_, done, err;
  logic [2:0] state_dbg;

  imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

  imem_loader #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE_ADDR)) dut (
    .clk       (clk),
    .rst_      (rst_),
    .start     (start),
    .bus       (bus),
    .core_rst_ (core_rst_),
    .done      (done),
    .err       (err),
    .state_dbg (state_dbg)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard ----------------
  int n_cmp  = 0;
  int n_fail = 0;
  // Expected write: {cycle seen at negedge, addr, data}
  logic [71:0] exp_q[$];
  logic [7:0]  frame_q[$];

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every write strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (bus.imem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_write: got addr %h data %h expected no write (cyc %0d)",
                 bus.imem_addr, bus.imem_wdata, cyc);
      end else begin
        check("imem_write", {cyc, bus.imem_addr, bus.imem_wdata}, exp_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  // All tasks start and end 1 time unit after a rising edge.
  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("start_status", {68'd0, bus.in_ready, core_rst_, done, err}, {68'd0, 4'b1000});
    @(posedge clk); #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap, input bit poke,
                           output int unsigned acc_cyc);
    bit got;
    for (int g = 0; g < gap; g++) begin
      bus.in_valid = 1'b0;
      bus.in_data  = 8'($urandom);
      start        = poke && (g == 0);
      @(posedge clk); #1;
      start = 1'b0;
    end
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    got = 1'b0;
    acc_cyc = 0;
    for (int t = 0; t < 40 && !got; t++) begin
      @(negedge clk);
      acc_cyc = cyc;
      got = bus.in_ready;
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    bus.in_data  = 8'($urandom);
    if (!got) begin
      n_cmp++;
      n_fail++;
      $display("FAIL byte_timeout: got in_ready=0 for 40 cycles expected 1");
    end
  endtask

  // Drives frame_q after a start pulse. The reference model reads the length,
  // decides how many bytes the loader consumes and the final outcome, and the
  // expected write for each word is queued as its last byte is sent.
  // limit > 0 stops after that many bytes without checking the outcome.
  task automatic run_frame(input int gap, input bit gap_rand, input bit poke, input int limit);
    int n, total, g;
    bit over, ok;
    logic [7:0] x;
    int unsigned acc;
    n     = int'({frame_q[1], frame_q[0]});
    over  = n > CAP;
    total = over ? 2 : 2 + 4 * n + 1;
    x = 8'h00;
    for (int k = 2; k < 2 + 4 * n && !over; k++) x ^= frame_q[k];
    ok = !over && (frame_q[total-1] == x);
    if (limit > 0 && limit < total) total = limit;

    pulse_start();
    for (int k = 0; k < total; k++) begin
      g = gap_rand ? $urandom_range(0, gap) : gap;
      send_byte(frame_q[k], g, poke, acc);
      if (!over && k >= 2 && k < 2 + 4 * n && ((k - 2) % 4) == 3) begin
        exp_q.push_back({acc + 32'd1, ADDR_W'(BASE_ADDR + (k - 2) / 4),
                         frame_q[k], frame_q[k-1], frame_q[k-2], frame_q[k-3]});
      end
    end
    if (limit == 0) begin
      @(negedge clk);
      check("end_status", {68'd0, bus.in_ready, core_rst_, done, err},
            {68'd0, 1'b0, ok, ok, !ok});
      repeat (2) @(posedge clk);
      #1;
    end
  endtask

  task automatic load_normal(input logic [7:0] csum_byte);
    logic [7:0] norm [11];
    norm = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h01, 8'hA0, 8'h00, 8'h71};
    frame_q.delete();
    for (int i = 0; i < 10; i++) frame_q.push_back(norm[i]);
    frame_q.push_back(csum_byte);
  endtask

  task automatic build_random(input int n, input bit good);
    logic [7:0] x, b;
    frame_q.delete();
    frame_q.push_back(n[7:0]);
    frame_q.push_back(n[15:8]);
    x = 8'h00;
    for (int i = 0; i < 4 * n; i++) begin
      b = 8'($urandom);
      x ^= b;
      frame_q.push_back(b);
    end
    frame_q.push_back(good ? x : x ^ 8'($urandom_range(1, 255)));
  endtask

  task automatic check_reset_values(input string name);
    @(negedge clk);
    check(name, {30'd0, bus.in_ready, bus.imem_we, bus.imem_addr, bus.imem_wdata,
                 core_rst_, done, err}, 72'd0);
    check({name, "_state"}, {69'd0, state_dbg}, 72'd0);
    @(posedge clk); #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    rst_ = 1'b0;
    check_reset_values("reset");

    // Normal two-word load, back-to-back bytes
    load_normal(8'h71);
    run_frame(0, 1'b0, 1'b0, 0);
    // Bad checksum: both writes still happen
    load_normal(8'h70);
    run_frame(0, 1'b0, 1'b0, 0);
    // Zero length
    frame_q = '{8'h00, 8'h00, 8'h00};
    run_frame(0, 1'b0, 1'b0, 0);
    // Gapped valid, three idle cycles before each byte
    load_normal(8'h71);
    run_frame(3, 1'b0, 1'b0, 0);
    // Overflow: N = 257
    frame_q = '{8'h01, 8'h01};
    run_frame(0, 1'b0, 1'b0, 0);
    // Largest legal frame fills IMEM exactly
    build_random(CAP, 1'b1);
    run_frame(0, 1'b0, 1'b0, 0);

    // Reset after five payload bytes, then reload
    load_normal(8'h71);
    run_frame(0, 1'b0, 1'b0, 7);
    rst_ = 1'b1;
    @(posedge clk); #1;
    rst_ = 1'b0;
    check_reset_values("mid_reset");
    load_normal(8'h71);
    run_frame(0, 1'b0, 1'b0, 0);

    // Randomized frames, random gaps, stray start pulses mid-load
    for (int r = 0; r < 24; r++) begin
      build_random($urandom_range(0, 6), $urandom_range(0, 3) != 0);
      run_frame(3, 1'b1, 1'($urandom_range(0, 1)), 0);
    end

    repeat (5) @(negedge clk);
    check("pending_writes", 72'(exp_q.size()), 72'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish expected finish before limit");
    $fatal(1, "timeout");
  end

endmodule
